// File: rtl/riscv_pkg.sv
// Shared RV64 definitions used by the decoder, ALU control and the
// multiply/divide unit.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: one result bit per cycle,
// shift-add multiply and restoring divide on magnitudes with sign fix-up.
module mul_div_unit #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    import riscv_pkg::*;

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    mdu_state_t        state;
    logic [2:0]        op_r;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    logic            sa;
    logic            sb;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            b_zero;
    logic            ovf;
    logic [XLEN-1:0] special;

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        unique case (op)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                sa = operand_a[XLEN-1];
                sb = operand_b[XLEN-1];
            end
            F3_MULHSU: sa = operand_a[XLEN-1];
            default: ;
        endcase
        abs_a   = sa ? neg(operand_a) : operand_a;
        abs_b   = sb ? neg(operand_b) : operand_b;
        b_zero  = (operand_b == '0);
        ovf     = !op[0]
                  && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                  && (operand_b == '1);
        special = b_zero ? (op[1] ? operand_a : '1)
                         : (op[1] ? '0 : operand_a);
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;

    always_comb begin
        hi      = acc[2*XLEN-1:XLEN];
        lo      = acc[XLEN-1:0];
        sum     = {1'b0, hi} + {1'b0, a_mag & {XLEN{lo[0]}}};
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b_mag};
        if (op_r[2]) begin
            acc_nxt = diff[XLEN]
                ? {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                : {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {sum, lo[XLEN-1:1]};
        end
    end

    logic [XLEN-1:0] p_lo;
    logic [XLEN-1:0] p_hi;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] final_res;

    always_comb begin
        p_lo = acc_nxt[XLEN-1:0];
        p_hi = acc_nxt[2*XLEN-1:XLEN];
        quo  = p_lo;
        rem  = p_hi;
        // 2*XLEN negate split across halves: borrow into hi only when lo is zero
        if (sign_a ^ sign_b) begin
            p_hi = (p_lo == '0) ? neg(p_hi) : ~p_hi;
            p_lo = neg(p_lo);
            quo  = neg(acc_nxt[XLEN-1:0]);
        end
        if (sign_a) begin
            rem = neg(acc_nxt[2*XLEN-1:XLEN]);
        end
        unique case (op_r)
            F3_MUL:                       final_res = p_lo;
            F3_MULH, F3_MULHSU, F3_MULHU: final_res = p_hi;
            F3_DIV, F3_DIVU:              final_res = quo;
            default:                      final_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_r   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        rd_out <= rd_in;
                        sign_a <= sa;
                        sign_b <= sb;
                        a_mag  <= abs_a;
                        b_mag  <= abs_b;
                        cnt    <= '0;
                        acc    <= {{XLEN{1'b0}}, op[2] ? abs_a : abs_b};
                        if (op[2] && (b_zero || ovf)) begin
                            result <= special;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result <= final_res;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_mul_div_unit;
    import riscv_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [4:0]   rd_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [4:0]   rd_out;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    logic   prev_done = 1'b0;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   rd;
        longint       at;
    } exp_t;

    exp_t sq[$];
    exp_t mon_e;

    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES = {W{1'b1}};

    mul_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic [2:0] o,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0]      xa;
        logic [2*W-1:0]      xb;
        logic [2*W-1:0]      p;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0]        r;
        sa = a;
        sb = b;
        xa = {{W{a[W-1]}}, a};
        xb = {{W{b[W-1]}}, b};
        r  = '0;
        case (o)
            F3_MUL:    r = a * b;
            F3_MULH:   begin p = xa * xb; r = p[2*W-1:W]; end
            F3_MULHSU: begin p = xa * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
            F3_MULHU:  begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
            F3_DIV:
                if (b == 0) r = ONES;
                else if (a == MIN && b == ONES) r = a;
                else r = sa / sb;
            F3_DIVU:   r = (b == 0) ? ONES : a / b;
            F3_REM:
                if (b == 0) r = a;
                else if (a == MIN && b == ONES) r = '0;
                else r = sa % sb;
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit fast(input logic [2:0] o,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b);
        if (!o[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !o[0] && a == MIN && b == ONES;
    endfunction

    task automatic check(input string name,
                         input logic [W-1:0] act,
                         input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            check("done_not_consecutive", W'(prev_done), W'(0));
            if (sq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
            end else begin
                mon_e = sq.pop_front();
                check("result", result, mon_e.res);
                check("rd_out", W'(rd_out), W'(mon_e.rd));
                check("done_cycle", W'(cyc), W'(mon_e.at));
            end
        end
        prev_done <= done;
    end

    // Called at posedge+1; waits for IDLE, presents one request, returns in cycle 1.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] r,
                         input logic [W-1:0] req);
        int   n;
        exp_t e;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL issue_wait actual=busy required=idle");
        end
        op        = o;
        operand_a = a;
        operand_b = b;
        rd_in     = r;
        start     = 1'b1;
        e.res = req;
        e.rd  = r;
        e.at  = cyc + (fast(o, a, b) ? 1 : W + 1);
        sq.push_back(e);
        @(posedge clk);
        #1;
        start     = 1'b0;
        operand_a = ~a;
        operand_b = ~b;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return ONES;
            2:       return MIN;
            3:       return W'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [2:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = '0;
        operand_a = '0;
        operand_b = '0;
        rd_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_result", result, '0);
        check("reset_rd_out", W'(rd_out), W'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(F3_MUL, 64'd7, 64'd6, 5'd5, 64'd42);
        for (int i = 1; i <= 66; i++) begin
            check($sformatf("busy_cycle_%0d", i), W'(busy), W'(i <= 65));
            if (i < 66) begin
                @(posedge clk);
                #1;
            end
        end
        check("result_held", result, 64'd42);
        check("rd_out_held", W'(rd_out), W'(5));

        issue(F3_MULH,   ONES, ONES, 5'd1, 64'd0);
        issue(F3_MULHU,  ONES, ONES, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(F3_MULHSU, ONES, 64'd2, 5'd3, ONES);
        issue(F3_DIV,    -64'sd7, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(F3_REM,    -64'sd7, 64'd2, 5'd6, ONES);
        issue(F3_DIVU,   64'd100, 64'd7, 5'd7, 64'd14);
        issue(F3_REMU,   64'd100, 64'd7, 5'd8, 64'd2);
        issue(F3_DIVU,   64'd5, 64'd0, 5'd9, ONES);
        issue(F3_REM,    64'd5, 64'd0, 5'd10, 64'd5);
        issue(F3_DIV,    MIN, ONES, 5'd11, MIN);
        issue(F3_REM,    MIN, ONES, 5'd12, 64'd0);

        // A start while busy must not disturb the running operation.
        issue(F3_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd13,
              64'hFFFF_FFFE_0000_0001);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        op        = F3_DIVU;
        operand_a = 64'd1;
        operand_b = 64'd0;
        rd_in     = 5'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset mid-operation, with a simultaneous start that must be dropped.
        issue(F3_DIV, 64'd1000, 64'd7, 5'd14, 64'd142);
        repeat (29) begin
            @(posedge clk);
            #1;
        end
        reset     = 1'b1;
        start     = 1'b1;
        op        = F3_MUL;
        operand_a = 64'd2;
        operand_b = 64'd2;
        rd_in     = 5'd15;
        sq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("post_reset_busy", W'(busy), W'(0));
        check("post_reset_result", result, '0);
        check("post_reset_rd_out", W'(rd_out), W'(0));
        @(posedge clk);
        #1;
        check("reset_drops_start", W'(busy), W'(0));
        repeat (80) @(posedge clk);
        #1;
        issue(F3_MUL, 64'd3, 64'd3, 5'd16, 64'd9);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, 5'($urandom_range(0, 31)), model(ro, ra, rb));
        end

        n = 0;
        while (sq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        check("scoreboard_drained", W'(sq.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV64M multiply/divide unit sitting directly downstream of the register file's read ports. It latches the two source operands (register file `ReadData1`/`ReadData2`) and destination index at `start`, computes one result bit per cycle, and presents a one-cycle `done` pulse with the result and `rd_out`. These feed the register file write port (`WriteData`, `RD`, `RegWrite`). `busy` stalls PC/instruction fetch while an operation is in flight.

## Interface
- `XLEN`, 64, operand/result width
- `CNT_W`, 7, iteration counter width; must satisfy 2^CNT_W > XLEN
- `clk`  in  1  single clock, all state updates on posedge
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`
- `start`  in  1  request; accepted only in IDLE
- `op`  in  3  RV64M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `operand_a`  in  XLEN  rs1 value (multiplicand/dividend)
- `operand_b`  in  XLEN  rs2 value (multiplier/divisor)
- `rd_in`  in  5  destination register index
- `busy`  out  1  high from cycle after acceptance through the `done` cycle
- `done`  out  1  one-cycle pulse; `result`/`rd_out` valid; drives `RegWrite`
- `result`  out  XLEN  final value; held until next acceptance
- `rd_out`  out  5  latched `rd_in`; held until next acceptance

## Operation
- States: IDLE, CALC, DONE.
- IDLE: when `start`=1, latch `op`, `rd_in`, and operand magnitudes with sign flags. Signed ops (MUL*, DIV, REM) take |a|, |b|; MULHSU signs only a. Clear counter.
  - Go to CALC.
  - Exception: DIV/DIVU/REM/REMU with b=0, or DIV/REM with a=0x8000_0000_0000_0000 and b=all-ones, goes straight to DONE with the special result.
- CALC: one iteration per cycle for XLEN cycles.
  - Multiply: shift-add into 2·XLEN accumulator.
  - Divide: restoring, XLEN-bit remainder, one quotient bit per cycle.
  - When counter reaches XLEN-1, go to DONE.
- DONE: apply sign fix-up (two's-complement negate).
  - Product negated if sign_a XOR sign_b (MULHSU: sign_a).
  - Quotient negated if signs differ; remainder takes dividend sign.
  - Select result: low half (MUL), high half (MULH*), quotient or remainder. Assert `done`, go to IDLE.
- Special results:
  - Divide by zero: quotient all-ones, remainder = a.
  - Signed overflow: quotient = a, remainder = 0.
- `start` while not IDLE is ignored. No queueing.
- Operands are latched at acceptance; later changes on `operand_a`/`operand_b` have no effect.
- All arithmetic is modulo 2^XLEN (2^(2·XLEN) for the product). Operands zero-extended for unsigned ops.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter 0, accumulators 0.
- Acceptance edge = E0 (`start`=1 in IDLE).
- Normal operation: `busy`=1 in cycles 1..XLEN+1. `done`=1 and `result` valid in cycle XLEN+1 (65 for XLEN=64). IDLE in cycle XLEN+2. Earliest next acceptance is at the end of cycle XLEN+2.
- Special-case fast path: `busy`=1 and `done`=1 in cycle 1 only.
- `done` is never high for two consecutive cycles.
- `busy` is combinational from state (state≠IDLE). `done` is combinational from state (DONE). `result`/`rd_out` are registered.
- `reset` in any state: next cycle IDLE with all reset values. A pending `done` is suppressed and no register write is issued.
- `reset` and `start` in the same cycle: `reset` wins; request dropped.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`
  - M-extension funct3 constants (`F3_MUL` … `F3_REMU`)
  - State enum `mdu_state_t` {IDLE, CALC, DONE}
  - Shared with decoder and ALU control.
- No sub-module required: single FSM plus datapath.
- The two's-complement negate is a local function, reused for operand conditioning and result fix-up.

## Test plan
- Reset, then MUL a=7 b=6 rd=5 → `busy` cycles 1–65, `done` only in cycle 65, `result`=42, `rd_out`=5.
- MULH a=all-ones b=all-ones → 0. MULHU same operands → 0xFFFF_FFFF_FFFF_FFFE. MULHSU a=all-ones b=2 → all-ones.
- DIV a=-7 b=2 → 0xFFFF_FFFF_FFFF_FFFD. REM a=-7 b=2 → all-ones. DIVU a=100 b=7 → 14. REMU a=100 b=7 → 2.
- DIVU a=5 b=0 → all-ones with `done` in cycle 1. REM a=5 b=0 → 5 with `done` in cycle 1.
- DIV a=0x8000_0000_0000_0000 b=-1 → 0x8000_0000_0000_0000 with `done` in cycle 1. REM same operands → 0.
- Second `start` at cycle 10 with different operands → ignored, first result intact. `reset` at cycle 30 → `busy`=0 in cycle 31, no `done` ever, `result`=0. A new MUL 3×3 then returns 9.
